// File: rtl/spi_input_conditioner_pkg.sv
// Shared SPI constants: debounce defaults and
// idle (reset) levels of the pad channels.
package spi_input_conditioner_pkg;

  localparam int SPI_WAIT = 3;
  localparam int SPI_COUNTER_WIDTH = 3;

  localparam logic SPI_IDLE_SCLK = 1'b0;
  localparam logic SPI_IDLE_CS = 1'b1;
  localparam logic SPI_IDLE_MOSI = 1'b0;

  localparam logic [2:0] SPI_IDLE = {
    SPI_IDLE_MOSI,
    SPI_IDLE_CS,
    SPI_IDLE_SCLK
  };

endpackage

// File: rtl/spi_input_conditioner_chan.sv
// One pad channel: 2-flop synchronizer,
// counter debounce and registered edge strobes.
module input_conditioner
  import spi_input_conditioner_pkg::*;
#(
  parameter int WAIT = SPI_WAIT,
  parameter int COUNTER_WIDTH = SPI_COUNTER_WIDTH,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  localparam logic [COUNTER_WIDTH-1:0] LAST =
    COUNTER_WIDTH'(WAIT - 1);

  logic sync1;
  logic sync2;
  logic [COUNTER_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      conditioned <= RESET_VAL;
      cnt <= '0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      // any agreeing sample restarts the run
      if (sync2 == conditioned) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        conditioned <= sync2;
        cnt <= '0;
        positiveedge <= sync2;
        negativeedge <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_input_conditioner.sv
// SPI pad front end: conditions sclk, cs and
// mosi for the slave FSM and shift register.
module spi_input_conditioner
  import spi_input_conditioner_pkg::*;
#(
  parameter int WAIT = SPI_WAIT,
  parameter int COUNTER_WIDTH = SPI_COUNTER_WIDTH,
  parameter logic [2:0] IDLE = SPI_IDLE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk_raw,
  input  logic cs_raw,
  input  logic mosi_raw,
  output logic sclk_cond,
  output logic sclk_posedge,
  output logic sclk_negedge,
  output logic cs_cond,
  output logic cs_posedge,
  output logic mosi_cond
);

  logic csNegedge;
  logic mosiPosedge;
  logic mosiNegedge;

  input_conditioner #(
    .WAIT(WAIT),
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .RESET_VAL(IDLE[0])
  ) sclkChan (
    .clk(clk),
    .reset_n(reset_n),
    .noisy(sclk_raw),
    .conditioned(sclk_cond),
    .positiveedge(sclk_posedge),
    .negativeedge(sclk_negedge)
  );

  input_conditioner #(
    .WAIT(WAIT),
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .RESET_VAL(IDLE[1])
  ) csChan (
    .clk(clk),
    .reset_n(reset_n),
    .noisy(cs_raw),
    .conditioned(cs_cond),
    .positiveedge(cs_posedge),
    .negativeedge(csNegedge)
  );

  input_conditioner #(
    .WAIT(WAIT),
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .RESET_VAL(IDLE[2])
  ) mosiChan (
    .clk(clk),
    .reset_n(reset_n),
    .noisy(mosi_raw),
    .conditioned(mosi_cond),
    .positiveedge(mosiPosedge),
    .negativeedge(mosiNegedge)
  );

  // strobes with no consumer downstream
  logic unusedOk;
  assign unusedOk = ^{csNegedge, mosiPosedge, mosiNegedge};

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Bench for spi_input_conditioner: window model
// checked every cycle plus directed scenarios.
module tb_spi_input_conditioner;

  localparam int WAIT = 3;
  localparam bit [2:0] IDLE = 3'b010;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sclk_raw = 1'b0;
  logic cs_raw = 1'b1;
  logic mosi_raw = 1'b0;
  logic sclk_cond;
  logic sclk_posedge;
  logic sclk_negedge;
  logic cs_cond;
  logic cs_posedge;
  logic mosi_cond;

  int total = 0;
  int bad = 0;

  spi_input_conditioner #(
    .WAIT(WAIT),
    .COUNTER_WIDTH(3),
    .IDLE(IDLE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sclk_raw(sclk_raw),
    .cs_raw(cs_raw),
    .mosi_raw(mosi_raw),
    .sclk_cond(sclk_cond),
    .sclk_posedge(sclk_posedge),
    .sclk_negedge(sclk_negedge),
    .cs_cond(cs_cond),
    .cs_posedge(cs_posedge),
    .mosi_cond(mosi_cond)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic checkInt(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: level flips once the last WAIT synchronized
  // samples all disagree and none predates the last event.
  bit [2:0] mP1 = IDLE;
  bit [2:0] mP2 = IDLE;
  bit [2:0] mCond = IDLE;
  bit [2:0] mPos = '0;
  bit [2:0] mNeg = '0;
  int since[3] = '{0, 0, 0};
  bit hist[3][$];

  always @(posedge clk or negedge reset_n) begin
    bit [2:0] rawV;
    bit s;
    bit allDiff;
    rawV = {mosi_raw, cs_raw, sclk_raw};
    for (int c = 0; c < 3; c++) begin
      if (!reset_n) begin
        mP1[c] = IDLE[c];
        mP2[c] = IDLE[c];
        mCond[c] = IDLE[c];
        mPos[c] = 1'b0;
        mNeg[c] = 1'b0;
        since[c] = 0;
        hist[c].delete();
      end else begin
        s = mP2[c];
        hist[c].push_back(s);
        if (hist[c].size() > WAIT) void'(hist[c].pop_front());
        since[c]++;
        mPos[c] = 1'b0;
        mNeg[c] = 1'b0;
        allDiff = 1'b1;
        foreach (hist[c][i])
          if (hist[c][i] == mCond[c]) allDiff = 1'b0;
        if (since[c] >= WAIT && allDiff) begin
          mCond[c] = s;
          mPos[c] = s;
          mNeg[c] = !s;
          since[c] = 0;
        end
        mP2[c] = mP1[c];
        mP1[c] = rawV[c];
      end
    end
  end

  int nSclkPos = 0;
  int nSclkNeg = 0;
  int nCsPos = 0;
  int nCsChg = 0;
  int nMosiHigh = 0;
  logic prevCs = 1'b1;

  always @(negedge clk) begin
    check("sclk_cond", sclk_cond, mCond[0]);
    check("sclk_posedge", sclk_posedge, mPos[0]);
    check("sclk_negedge", sclk_negedge, mNeg[0]);
    check("cs_cond", cs_cond, mCond[1]);
    check("cs_posedge", cs_posedge, mPos[1]);
    check("mosi_cond", mosi_cond, mCond[2]);
    nSclkPos += int'(sclk_posedge === 1'b1);
    nSclkNeg += int'(sclk_negedge === 1'b1);
    nCsPos += int'(cs_posedge === 1'b1);
    nMosiHigh += int'(mosi_cond === 1'b1);
    if (cs_cond !== prevCs) nCsChg++;
    prevCs = cs_cond;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int b0;
    int b1;
    int b2;

    // reset with random pads
    for (int i = 0; i < 4; i++) begin
      tick(1);
      sclk_raw = 1'($urandom);
      cs_raw = 1'($urandom);
      mosi_raw = 1'($urandom);
    end
    tick(1);
    check("rst sclk_cond", sclk_cond, 1'b0);
    check("rst cs_cond", cs_cond, 1'b1);
    check("rst mosi_cond", mosi_cond, 1'b0);
    check("rst sclk_posedge", sclk_posedge, 1'b0);
    check("rst sclk_negedge", sclk_negedge, 1'b0);
    check("rst cs_posedge", cs_posedge, 1'b0);
    sclk_raw = 1'b0;
    cs_raw = 1'b1;
    mosi_raw = 1'b0;
    b0 = nSclkPos + nSclkNeg + nCsPos;
    reset_n = 1'b1;
    tick(8);
    checkInt("release strobes", nSclkPos + nSclkNeg + nCsPos, b0);

    // clean sclk edges, 5-edge latency
    sclk_raw = 1'b1;
    tick(4);
    check("rise early cond", sclk_cond, 1'b0);
    tick(1);
    check("rise cond", sclk_cond, 1'b1);
    check("rise strobe", sclk_posedge, 1'b1);
    tick(1);
    check("rise strobe off", sclk_posedge, 1'b0);
    sclk_raw = 1'b0;
    tick(4);
    check("fall early cond", sclk_cond, 1'b1);
    tick(1);
    check("fall strobe", sclk_negedge, 1'b1);
    check("fall cond", sclk_cond, 1'b0);
    tick(1);
    check("fall strobe off", sclk_negedge, 1'b0);

    // mosi glitch rejected, 3-cycle pulse kept
    b0 = nMosiHigh;
    mosi_raw = 1'b1;
    tick(2);
    mosi_raw = 1'b0;
    tick(10);
    checkInt("glitch2 high", nMosiHigh - b0, 0);
    b0 = nMosiHigh;
    mosi_raw = 1'b1;
    tick(3);
    mosi_raw = 1'b0;
    tick(10);
    checkInt("pulse3 high", nMosiHigh - b0, 3);

    // cs bounce, one transition only
    b0 = nCsChg;
    b1 = nCsPos;
    cs_raw = 1'b1;
    tick(1);
    cs_raw = 1'b0;
    tick(1);
    cs_raw = 1'b1;
    tick(1);
    cs_raw = 1'b0;
    tick(4);
    check("bounce early", cs_cond, 1'b1);
    tick(1);
    check("bounce settle", cs_cond, 1'b0);
    tick(8);
    checkInt("bounce changes", nCsChg - b0, 1);
    checkInt("bounce cs_posedge", nCsPos - b1, 0);
    cs_raw = 1'b1;
    tick(8);

    // reset in the middle of a count
    b0 = nSclkPos;
    sclk_raw = 1'b1;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    check("midrst cond", sclk_cond, 1'b0);
    reset_n = 1'b1;
    tick(4);
    check("midrst early", sclk_cond, 1'b0);
    checkInt("midrst no strobe", nSclkPos - b0, 0);
    tick(1);
    check("midrst cond", sclk_cond, 1'b1);
    check("midrst strobe", sclk_posedge, 1'b1);
    tick(4);
    checkInt("midrst strobes", nSclkPos - b0, 1);

    // all three flip together
    sclk_raw = 1'b0;
    tick(8);
    b2 = nCsPos;
    sclk_raw = 1'b1;
    cs_raw = 1'b0;
    mosi_raw = 1'b1;
    tick(5);
    check("sim sclk_posedge", sclk_posedge, 1'b1);
    check("sim cs_negedge", dut.csNegedge, 1'b1);
    check("sim mosi_cond", mosi_cond, 1'b1);
    check("sim cs_cond", cs_cond, 1'b0);
    check("sim cs_posedge", cs_posedge, 1'b0);
    checkInt("sim cs_posedge cnt", nCsPos - b2, 0);
    cs_raw = 1'b1;
    mosi_raw = 1'b0;
    tick(8);

    // random hold lengths, model only
    for (int i = 0; i < 60; i++) begin
      sclk_raw = 1'($urandom);
      cs_raw = 1'($urandom);
      mosi_raw = 1'($urandom);
      tick($urandom_range(1, 7));
    end
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
